// File: rtl/sc_game_pkg.sv
// Shared encodings and widths for the Frogger game-level sequencer.
package sc_game_pkg;

  localparam int LIVES_W       = 2;
  localparam int LEVEL_W       = 2;
  localparam int TICK_BASE_DEF = 25000000;
  localparam int TICK_STEP_DEF = 5000000;

  typedef logic [LIVES_W-1:0] lives_t;
  typedef logic [LEVEL_W-1:0] level_t;

  typedef enum logic [3:0] {
    ST_RESET    = 4'd0,
    ST_IDLE     = 4'd1,
    ST_INIT     = 4'd2,
    ST_RESPAWN  = 4'd3,
    ST_PLAY     = 4'd4,
    ST_HIT      = 4'd5,
    ST_LEVELUP  = 4'd6,
    ST_GAMEOVER = 4'd7,
    ST_WIN      = 4'd8
  } state_t;

endpackage

// File: rtl/sc_game_ticker.sv
// Obstacle-lane pacing: counts while running and strobes (active-low) once per
// level-dependent period, wrapping to zero on the strobe cycle.
module sc_game_ticker
  import sc_game_pkg::*;
#(
  parameter int TICK_BASE = TICK_BASE_DEF,
  parameter int TICK_STEP = TICK_STEP_DEF,
  parameter int CNT_WIDTH = 26
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   run,
  input  level_t level,
  output logic   shift_n
);

  localparam logic [CNT_WIDTH-1:0] BASE_M1 = CNT_WIDTH'(TICK_BASE - 1);
  localparam logic [CNT_WIDTH-1:0] STEP    = CNT_WIDTH'(TICK_STEP);

  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] last;
  logic                 wrap;

  // Last count of the period; level*STEP never exceeds BASE_M1 for legal configs.
  assign last    = BASE_M1 - CNT_WIDTH'(level) * STEP;
  assign wrap    = run && (cnt == last);
  assign shift_n = ~wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               cnt <= '0;
    else if (!run || wrap) cnt <= '0;
    else                   cnt <= cnt + CNT_WIDTH'(1);
  end

endmodule

// File: rtl/sc_statemachinegame.sv
// Frogger round sequencer: start, lives, levels, collision and win/game-over
// handling, driving active-low clear/shift strobes into the datapath.
module sc_statemachinegame
  import sc_game_pkg::*;
#(
  parameter int TICK_BASE  = TICK_BASE_DEF,
  parameter int TICK_STEP  = TICK_STEP_DEF,
  parameter int LEVEL_MAX  = 3,
  parameter int LIVES_INIT = 3,
  parameter int CNT_WIDTH  = 26
) (
  input  logic       SC_STATEMACHINEGAME_CLOCK_50,
  input  logic       SC_STATEMACHINEGAME_RESET_InHigh,
  input  logic       SC_STATEMACHINEGAME_startButton_InLow,
  input  logic       SC_STATEMACHINEGAME_collision_InLow,
  input  logic       SC_STATEMACHINEGAME_topside_InLow,
  output logic       SC_STATEMACHINEGAME_frogclear_OutLow,
  output logic       SC_STATEMACHINEGAME_obstacleclear_OutLow,
  output logic       SC_STATEMACHINEGAME_obstacleshift_OutLow,
  output logic [1:0] SC_STATEMACHINEGAME_lives_Out,
  output logic [1:0] SC_STATEMACHINEGAME_level_Out,
  output logic       SC_STATEMACHINEGAME_gameover_Out,
  output logic       SC_STATEMACHINEGAME_win_Out
);

  if (TICK_BASE <= LEVEL_MAX * TICK_STEP) begin : g_bad_cfg
    $error("sc_statemachinegame: TICK_BASE must exceed LEVEL_MAX*TICK_STEP");
  end

  localparam level_t LVL_MAX  = level_t'(LEVEL_MAX);
  localparam lives_t LIVES_LD = lives_t'(LIVES_INIT);

  logic   clk, rst;
  logic   start_n, col_n, top_n;
  state_t state, state_nxt;
  lives_t lives, lives_nxt;
  level_t level, level_nxt;
  logic   frogclear_n, obsclear_n, gameover, win;

  assign clk     = SC_STATEMACHINEGAME_CLOCK_50;
  assign rst     = SC_STATEMACHINEGAME_RESET_InHigh;
  assign start_n = SC_STATEMACHINEGAME_startButton_InLow;
  assign col_n   = SC_STATEMACHINEGAME_collision_InLow;
  assign top_n   = SC_STATEMACHINEGAME_topside_InLow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RESET;
      lives <= '0;
      level <= '0;
    end else begin
      state <= state_nxt;
      lives <= lives_nxt;
      level <= level_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    lives_nxt   = lives;
    level_nxt   = level;
    frogclear_n = 1'b1;
    obsclear_n  = 1'b1;
    gameover    = 1'b0;
    win         = 1'b0;
    case (state)
      ST_RESET: begin
        frogclear_n = 1'b0;
        obsclear_n  = 1'b0;
        state_nxt   = ST_IDLE;
      end
      ST_IDLE: if (!start_n) state_nxt = ST_INIT;
      ST_INIT: begin
        frogclear_n = 1'b0;
        obsclear_n  = 1'b0;
        lives_nxt   = LIVES_LD;
        level_nxt   = '0;
        state_nxt   = ST_RESPAWN;
      end
      // Wait for every input to be released so a held button or a frog
      // spawning onto an obstacle cannot immediately retrigger.
      ST_RESPAWN: if (start_n && col_n && top_n) state_nxt = ST_PLAY;
      ST_PLAY: begin
        if (!col_n) begin
          if (lives > lives_t'(1)) begin
            state_nxt = ST_HIT;
          end else begin
            lives_nxt = '0;
            state_nxt = ST_GAMEOVER;
          end
        end else if (!top_n) begin
          if (level < LVL_MAX) state_nxt = ST_LEVELUP;
          else                 state_nxt = ST_WIN;
        end
      end
      ST_HIT: begin
        frogclear_n = 1'b0;
        lives_nxt   = lives - lives_t'(1);
        state_nxt   = ST_RESPAWN;
      end
      ST_LEVELUP: begin
        frogclear_n = 1'b0;
        obsclear_n  = 1'b0;
        level_nxt   = level + level_t'(1);
        state_nxt   = ST_RESPAWN;
      end
      ST_GAMEOVER: begin
        gameover = 1'b1;
        if (!start_n) state_nxt = ST_INIT;
      end
      ST_WIN: begin
        win = 1'b1;
        if (!start_n) state_nxt = ST_INIT;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  sc_game_ticker #(
    .TICK_BASE (TICK_BASE),
    .TICK_STEP (TICK_STEP),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_ticker (
    .clk     (clk),
    .rst     (rst),
    .run     (state == ST_PLAY),
    .level   (level),
    .shift_n (SC_STATEMACHINEGAME_obstacleshift_OutLow)
  );

  assign SC_STATEMACHINEGAME_frogclear_OutLow     = frogclear_n;
  assign SC_STATEMACHINEGAME_obstacleclear_OutLow = obsclear_n;
  assign SC_STATEMACHINEGAME_lives_Out            = lives;
  assign SC_STATEMACHINEGAME_level_Out            = level;
  assign SC_STATEMACHINEGAME_gameover_Out         = gameover;
  assign SC_STATEMACHINEGAME_win_Out              = win;

endmodule

// File: doc/sc_statemachinegame.md
Name: sc_statemachinegame

Overview:
- Game-level sequencer for Frogger.
- Runs the round: start, lives, levels, collision handling, win/game-over. Paces the obstacle lanes with a level-dependent shift tick.
- Drives frog-register clear and obstacle-lane clear/shift strobes (all active-low, matching the datapath).
- Sits beside the point (frog movement) state machine. Consumes collision and top-row comparator flags from the datapath.

Parameters:
- TICK_BASE, 25000000, shift period in clocks at level 0 (0.5 s at 50 MHz).
- TICK_STEP, 5000000, period reduction per level.
- LEVEL_MAX, 3, highest level index; must fit 2 bits.
- LIVES_INIT, 3, lives loaded at game start; must fit 2 bits, nonzero.
- CNT_WIDTH, 26, tick counter width; must hold TICK_BASE-1.
- Legal only if TICK_BASE > LEVEL_MAX*TICK_STEP.

Ports:
- SC_STATEMACHINEGAME_CLOCK_50  in  1  system clock, 50 MHz.
- SC_STATEMACHINEGAME_RESET_InHigh  in  1  reset; asynchronous, active-high.
- SC_STATEMACHINEGAME_startButton_InLow  in  1  start button, low = pressed.
- SC_STATEMACHINEGAME_collision_InLow  in  1  frog overlaps an obstacle, low = hit.
- SC_STATEMACHINEGAME_topside_InLow  in  1  frog in top row, low = reached.
- SC_STATEMACHINEGAME_frogclear_OutLow  out  1  clear frog register to start position.
- SC_STATEMACHINEGAME_obstacleclear_OutLow  out  1  reload obstacle lanes.
- SC_STATEMACHINEGAME_obstacleshift_OutLow  out  1  one-cycle shift strobe for all lanes.
- SC_STATEMACHINEGAME_lives_Out  out  2  remaining lives.
- SC_STATEMACHINEGAME_level_Out  out  2  current level.
- SC_STATEMACHINEGAME_gameover_Out  out  1  high in GAMEOVER.
- SC_STATEMACHINEGAME_win_Out  out  1  high in WIN.

Behaviour:
- One clock. Reset is asynchronous and active-high. On reset: state=RESET, lives=0, level=0, tick counter=0.
- Moore FSM, 4-bit state register. States: RESET=0, IDLE=1, INIT=2, RESPAWN=3, PLAY=4, HIT=5, LEVELUP=6, GAMEOVER=7, WIN=8. Undefined encodings go to IDLE.
- Transitions:
  - RESET -> IDLE.
  - IDLE: start low -> INIT; else stay.
  - INIT: lives<=LIVES_INIT, level<=0 -> RESPAWN.
  - RESPAWN: start, collision and topside all high -> PLAY; else stay. This guards against held buttons and spawning onto an obstacle.
  - PLAY, priority collision > topside:
    - collision low and lives>1 -> HIT.
    - collision low and lives==1 -> lives<=0 -> GAMEOVER.
    - topside low and level<LEVEL_MAX -> LEVELUP.
    - topside low and level==LEVEL_MAX -> WIN.
  - HIT: lives<=lives-1 -> RESPAWN.
  - LEVELUP: level<=level+1 -> RESPAWN.
  - GAMEOVER / WIN: start low -> INIT.
- Outputs per state (strobes are 1 unless listed):
  - RESET: frogclear=0, obstacleclear=0.
  - INIT: frogclear=0, obstacleclear=0.
  - HIT: frogclear=0. Obstacles keep position.
  - LEVELUP: frogclear=0, obstacleclear=0.
  - GAMEOVER: gameover=1.
  - WIN: win=1.
  - lives_Out and level_Out are the registers directly.
- Tick counter:
  - Counts only in PLAY; held at 0 in every other state.
  - period = TICK_BASE - level*TICK_STEP.
  - obstacleshift_OutLow=0 for exactly the PLAY cycle where counter==period-1. Counter wraps to 0 on that edge.
  - First shift comes `period` cycles after entering PLAY.
  - If PLAY is exited on the wrap cycle, the strobe still fires that cycle.
- Lives never underflow; decrement happens only from HIT (lives>=2). Level never exceeds LEVEL_MAX.
- Reset mid-game returns immediately to RESET values, with no further strobes.

Decomposition:
- Shared package sc_game_pkg holds the state encodings, 2-bit lives/level widths, and the default TICK_BASE/TICK_STEP.
- One natural sub-module: sc_game_ticker. It takes the counter, level and run enable, and emits the shift strobe.
- The FSM plus lives/level registers stay in sc_statemachinegame.

Test Plan:
All scenarios use TICK_BASE=10, TICK_STEP=2, LEVEL_MAX=2, LIVES_INIT=3.
1. Reset asserted mid-cycle -> immediate RESET outputs (frogclear=0, obstacleclear=0, lives=0). Release -> IDLE after 1 clock, shift stays 1.
2. IDLE, start low 3 cycles then high -> one INIT cycle (both clears 0) and lives=3. Stays RESPAWN while start is held. Then in PLAY, shift strobes at cycles 10, 20, 30 after entry, each exactly 1 cycle wide.
3. In PLAY, collision low for 6 cycles -> one HIT cycle (frogclear=0), lives 3->2. Stays RESPAWN until collision high, with no shift strobes during RESPAWN.
4. Three separate collisions -> lives 3->2->1->0 and gameover=1, no HIT on the last. Start low -> INIT, lives=3, level=0.
5. Topside low at level 0 -> LEVELUP (frog and obstacle clear), level=1, shift period 8. Topside at level 1 -> period 6. Topside at level 2 -> win=1.
6. Collision and topside low in the same PLAY cycle -> HIT path taken, level unchanged, lives decremented.
